// File: rtl/iq_pkg.sv
// Shared constants and the dispatch-slot record for the issue-queue dispatch stage.
package iq_pkg;
  localparam int OPCODE    = 7;
  localparam int PRF_WIDTH = 6;
  localparam int AGE       = 5;
  localparam int WB_PORTS  = 2;
  localparam int DW        = 4;
  localparam int IQ_DEPTH  = 16;
  localparam int NUM_PREGS = 2 ** PRF_WIDTH;

  typedef logic [PRF_WIDTH-1:0] preg_t;

  typedef struct packed {
    logic [OPCODE-1:0] op;
    preg_t             prs1;
    logic              prs1_v;
    logic              prs1_rdy;
    preg_t             prs2;
    logic              prs2_v;
    logic              prs2_rdy;
    preg_t             prd;
    logic              prd_v;
    logic [AGE-1:0]    age;
  } dsp_slot_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/prf_busy_table.sv
// Physical-register busy bits: set by dispatch, cleared by writeback, read with writeback bypass.
module prf_busy_table
  import iq_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [DW-1:0]                 set_en,
  input  logic [DW*PRF_WIDTH-1:0]       set_tag,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*PRF_WIDTH-1:0] wb_tag,
  input  logic [2*DW*PRF_WIDTH-1:0]     rd_tag,
  output logic [2*DW-1:0]               rd_busy
);
  logic [NUM_PREGS-1:0] busy_q;
  logic [NUM_PREGS-1:0] busy_d;
  preg_t                tag;
  logic                 hit;

  // Sets are applied after clears so a same-cycle set of an entry wins.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < WB_PORTS; w++)
      if (wb_valid[w]) busy_d[wb_tag[w*PRF_WIDTH +: PRF_WIDTH]] = 1'b0;
    for (int i = 0; i < DW; i++)
      if (set_en[i]) busy_d[set_tag[i*PRF_WIDTH +: PRF_WIDTH]] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     busy_q <= '0;
    else if (flush) busy_q <= '0;
    else            busy_q <= busy_d;
  end

  always_comb begin
    rd_busy = '0;
    tag     = '0;
    hit     = 1'b0;
    for (int r = 0; r < 2*DW; r++) begin
      tag = rd_tag[r*PRF_WIDTH +: PRF_WIDTH];
      hit = 1'b0;
      for (int w = 0; w < WB_PORTS; w++)
        if (wb_valid[w] && (wb_tag[w*PRF_WIDTH +: PRF_WIDTH] == tag)) hit = 1'b1;
      rd_busy[r] = busy_q[tag] && !hit;
    end
  end
endmodule

// File: rtl/iq_dispatch.sv
// Dispatch stage: readiness lookup, intra-group dependence, age tagging and the
// output register that waits for issue-queue space.
module iq_dispatch
  import iq_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [DW-1:0]                 ren_valid,
  output logic                          ren_ready,
  input  logic [DW*OPCODE-1:0]          ren_op,
  input  logic [DW*PRF_WIDTH-1:0]       ren_prs1,
  input  logic [DW*PRF_WIDTH-1:0]       ren_prs2,
  input  logic [DW*PRF_WIDTH-1:0]       ren_prd,
  input  logic [DW-1:0]                 ren_prs1_v,
  input  logic [DW-1:0]                 ren_prs2_v,
  input  logic [DW-1:0]                 ren_prd_v,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*PRF_WIDTH-1:0] wb_prd,
  input  logic [4:0]                    iq_free_cnt,
  output logic [DW-1:0]                 dsp_valid,
  output logic                          dsp_fire,
  output logic [DW*OPCODE-1:0]          dsp_op,
  output logic [DW*PRF_WIDTH-1:0]       dsp_prs1,
  output logic [DW*PRF_WIDTH-1:0]       dsp_prs2,
  output logic [DW*PRF_WIDTH-1:0]       dsp_prd,
  output logic [DW-1:0]                 dsp_prs1_v,
  output logic [DW-1:0]                 dsp_prs2_v,
  output logic [DW-1:0]                 dsp_prd_v,
  output logic [DW-1:0]                 dsp_prs1_rdy,
  output logic [DW-1:0]                 dsp_prs2_rdy,
  output logic [DW*AGE-1:0]             dsp_age
);
  dsp_slot_t [DW-1:0]           slot_q, grp, new_slot, held_slot;
  logic [DW-1:0]                valid_q;
  logic [AGE-1:0]               age_cnt_q;
  logic [AGE-1:0]               rank;
  logic [2:0]                   n_out;
  logic                         accept;
  logic [DW-1:0]                set_en;
  logic [DW*PRF_WIDTH-1:0]      set_tag;
  logic [2*DW*PRF_WIDTH-1:0]    rd_tag;
  logic [2*DW-1:0]              rd_busy;
  logic                         redef1, redef2;

  assign n_out     = popcount4(valid_q);
  assign dsp_fire  = (n_out != 3'd0) && (iq_free_cnt >= {2'b00, n_out});
  assign ren_ready = (n_out == 3'd0) || dsp_fire;
  assign accept    = ren_ready && (|ren_valid);

  prf_busy_table u_busy (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .set_en   (set_en),
    .set_tag  (set_tag),
    .wb_valid (wb_valid),
    .wb_tag   (wb_prd),
    .rd_tag   (rd_tag),
    .rd_busy  (rd_busy)
  );

  // Unpack the incoming group, assign ages by rank and drive busy-table ports.
  always_comb begin
    grp     = '0;
    rd_tag  = '0;
    set_en  = '0;
    set_tag = '0;
    rank    = '0;
    for (int i = 0; i < DW; i++) begin
      grp[i].op     = ren_op[i*OPCODE +: OPCODE];
      grp[i].prs1   = ren_prs1[i*PRF_WIDTH +: PRF_WIDTH];
      grp[i].prs2   = ren_prs2[i*PRF_WIDTH +: PRF_WIDTH];
      grp[i].prd    = ren_prd[i*PRF_WIDTH +: PRF_WIDTH];
      grp[i].prs1_v = ren_prs1_v[i];
      grp[i].prs2_v = ren_prs2_v[i];
      grp[i].prd_v  = ren_prd_v[i];
      grp[i].age    = age_cnt_q + rank;
      if (ren_valid[i]) rank = rank + AGE'(1);
      rd_tag[(2*i)*PRF_WIDTH +: PRF_WIDTH]   = ren_prs1[i*PRF_WIDTH +: PRF_WIDTH];
      rd_tag[(2*i+1)*PRF_WIDTH +: PRF_WIDTH] = ren_prs2[i*PRF_WIDTH +: PRF_WIDTH];
      set_en[i] = accept && ren_valid[i] && ren_prd_v[i] &&
                  (ren_prd[i*PRF_WIDTH +: PRF_WIDTH] != '0);
      set_tag[i*PRF_WIDTH +: PRF_WIDTH] = ren_prd[i*PRF_WIDTH +: PRF_WIDTH];
    end
  end

  // An older slot writing the same tag overrides both the busy table and the bypass.
  always_comb begin
    new_slot = grp;
    redef1   = 1'b0;
    redef2   = 1'b0;
    for (int i = 0; i < DW; i++) begin
      redef1 = 1'b0;
      redef2 = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (ren_valid[j] && grp[j].prd_v && (grp[j].prd == grp[i].prs1)) redef1 = 1'b1;
        if (ren_valid[j] && grp[j].prd_v && (grp[j].prd == grp[i].prs2)) redef2 = 1'b1;
      end
      new_slot[i].prs1_rdy = !grp[i].prs1_v || (grp[i].prs1 == '0) ||
                             (!rd_busy[2*i] && !redef1);
      new_slot[i].prs2_rdy = !grp[i].prs2_v || (grp[i].prs2 == '0) ||
                             (!rd_busy[2*i+1] && !redef2);
    end
  end

  always_comb begin
    held_slot = slot_q;
    for (int i = 0; i < DW; i++)
      for (int w = 0; w < WB_PORTS; w++) begin
        if (wb_valid[w] && (wb_prd[w*PRF_WIDTH +: PRF_WIDTH] == slot_q[i].prs1))
          held_slot[i].prs1_rdy = 1'b1;
        if (wb_valid[w] && (wb_prd[w*PRF_WIDTH +: PRF_WIDTH] == slot_q[i].prs2))
          held_slot[i].prs2_rdy = 1'b1;
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      slot_q    <= '0;
      age_cnt_q <= '0;
    end else if (flush) begin
      valid_q   <= '0;
      age_cnt_q <= '0;
    end else if (accept) begin
      valid_q   <= ren_valid;
      slot_q    <= new_slot;
      age_cnt_q <= age_cnt_q + AGE'(popcount4(ren_valid));
    end else if (dsp_fire) begin
      valid_q   <= '0;
    end else begin
      slot_q    <= held_slot;
    end
  end

  always_comb begin
    dsp_valid    = valid_q;
    dsp_op       = '0;
    dsp_prs1     = '0;
    dsp_prs2     = '0;
    dsp_prd      = '0;
    dsp_prs1_v   = '0;
    dsp_prs2_v   = '0;
    dsp_prd_v    = '0;
    dsp_prs1_rdy = '0;
    dsp_prs2_rdy = '0;
    dsp_age      = '0;
    for (int i = 0; i < DW; i++) begin
      dsp_op[i*OPCODE +: OPCODE]      = slot_q[i].op;
      dsp_prs1[i*PRF_WIDTH +: PRF_WIDTH] = slot_q[i].prs1;
      dsp_prs2[i*PRF_WIDTH +: PRF_WIDTH] = slot_q[i].prs2;
      dsp_prd[i*PRF_WIDTH +: PRF_WIDTH]  = slot_q[i].prd;
      dsp_prs1_v[i]   = slot_q[i].prs1_v;
      dsp_prs2_v[i]   = slot_q[i].prs2_v;
      dsp_prd_v[i]    = slot_q[i].prd_v;
      dsp_prs1_rdy[i] = slot_q[i].prs1_rdy;
      dsp_prs2_rdy[i] = slot_q[i].prs2_rdy;
      dsp_age[i*AGE +: AGE] = slot_q[i].age;
    end
  end

  a_ren_valid_contig: assert property (@(posedge clk) disable iff (!rst_n)
    ren_valid inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111})
    else $error("iq_dispatch: non-contiguous ren_valid %b", ren_valid);
endmodule

// File: tb/tb_iq_dispatch.sv
// Directed bench for iq_dispatch with a per-cycle reference model and literal spot checks.
module tb_iq_dispatch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush;
  logic [3:0]  ren_valid;
  logic        ren_ready;
  logic [27:0] ren_op;
  logic [23:0] ren_prs1, ren_prs2, ren_prd;
  logic [3:0]  ren_prs1_v, ren_prs2_v, ren_prd_v;
  logic [1:0]  wb_valid;
  logic [11:0] wb_prd;
  logic [4:0]  iq_free_cnt;
  logic [3:0]  dsp_valid;
  logic        dsp_fire;
  logic [27:0] dsp_op;
  logic [23:0] dsp_prs1, dsp_prs2, dsp_prd;
  logic [3:0]  dsp_prs1_v, dsp_prs2_v, dsp_prd_v, dsp_prs1_rdy, dsp_prs2_rdy;
  logic [19:0] dsp_age;

  int total = 0;
  int bad   = 0;

  iq_dispatch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ren_valid(ren_valid), .ren_ready(ren_ready), .ren_op(ren_op),
    .ren_prs1(ren_prs1), .ren_prs2(ren_prs2), .ren_prd(ren_prd),
    .ren_prs1_v(ren_prs1_v), .ren_prs2_v(ren_prs2_v), .ren_prd_v(ren_prd_v),
    .wb_valid(wb_valid), .wb_prd(wb_prd), .iq_free_cnt(iq_free_cnt),
    .dsp_valid(dsp_valid), .dsp_fire(dsp_fire), .dsp_op(dsp_op),
    .dsp_prs1(dsp_prs1), .dsp_prs2(dsp_prs2), .dsp_prd(dsp_prd),
    .dsp_prs1_v(dsp_prs1_v), .dsp_prs2_v(dsp_prs2_v), .dsp_prd_v(dsp_prd_v),
    .dsp_prs1_rdy(dsp_prs1_rdy), .dsp_prs2_rdy(dsp_prs2_rdy), .dsp_age(dsp_age)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_busy[64];
  int m_cnt = 0;
  bit m_v[4];
  int m_op[4], m_p1[4], m_p2[4], m_pd[4], m_age[4];
  bit m_p1v[4], m_p2v[4], m_pdv[4], m_r1[4], m_r2[4];

  function automatic void model_reset();
    for (int k = 0; k < 64; k++) m_busy[k] = 0;
    for (int i = 0; i < 4; i++) m_v[i] = 0;
    m_cnt = 0;
  endfunction

  function automatic int held_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m_v[i]);
    return n;
  endfunction

  function automatic bit wb_hit(input int tag);
    for (int w = 0; w < 2; w++)
      if (wb_valid[w] && int'(wb_prd[w*6 +: 6]) == tag) return 1;
    return 0;
  endfunction

  function automatic bit src_ready(input int slot, input int tag, input bit present);
    bit redef = 0;
    if (!present || tag == 0) return 1;
    for (int j = 0; j < slot; j++)
      if (ren_valid[j] && ren_prd_v[j] && int'(ren_prd[j*6 +: 6]) == tag) redef = 1;
    return (!m_busy[tag] || wb_hit(tag)) && !redef;
  endfunction

  function automatic void model_step();
    int n, rank, added;
    bit efire, erdy, acc;
    bit nb[64];
    if (!rst_n) begin model_reset(); return; end
    if (flush) begin model_reset(); return; end
    n     = held_count();
    efire = (n > 0) && (int'(iq_free_cnt) >= n);
    erdy  = (n == 0) || efire;
    acc   = erdy && (ren_valid != 4'b0);
    nb    = m_busy;
    for (int w = 0; w < 2; w++) if (wb_valid[w]) nb[int'(wb_prd[w*6 +: 6])] = 0;
    if (acc) begin
      rank = 0;
      added = 0;
      for (int i = 0; i < 4; i++) begin
        m_v[i]   = ren_valid[i];
        m_op[i]  = int'(ren_op[i*7 +: 7]);
        m_p1[i]  = int'(ren_prs1[i*6 +: 6]);
        m_p2[i]  = int'(ren_prs2[i*6 +: 6]);
        m_pd[i]  = int'(ren_prd[i*6 +: 6]);
        m_p1v[i] = ren_prs1_v[i];
        m_p2v[i] = ren_prs2_v[i];
        m_pdv[i] = ren_prd_v[i];
        m_r1[i]  = src_ready(i, m_p1[i], m_p1v[i]);
        m_r2[i]  = src_ready(i, m_p2[i], m_p2v[i]);
        m_age[i] = (m_cnt + rank) % 32;
        if (ren_valid[i]) begin
          rank++;
          added++;
          if (m_pdv[i] && m_pd[i] != 0) nb[m_pd[i]] = 1;
        end
      end
      m_cnt = (m_cnt + added) % 32;
    end else if (efire) begin
      for (int i = 0; i < 4; i++) m_v[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wb_hit(m_p1[i])) m_r1[i] = 1;
        if (wb_hit(m_p2[i])) m_r2[i] = 1;
      end
    end
    nb[0] = 0;
    m_busy = nb;
  endfunction

  function automatic logic [63:0] pack_slot(input int op, input int p1, input bit p1v, input bit r1,
                                            input int p2, input bit p2v, input bit r2,
                                            input int pd, input bit pdv, input int age);
    return {29'd0, 7'(op), 6'(p1), p1v, r1, 6'(p2), p2v, r2, 6'(pd), pdv, 5'(age)};
  endfunction

  // Single compare process: inputs settle at the falling edge, compare 2 units later.
  always begin
    int n;
    bit efire;
    logic [3:0] ev;
    @(negedge clk);
    #2;
    if (!rst_n) model_reset();
    n     = held_count();
    efire = (n > 0) && (int'(iq_free_cnt) >= n);
    ev    = {m_v[3], m_v[2], m_v[1], m_v[0]};
    check("dsp_valid", 64'(dsp_valid), 64'(ev));
    check("dsp_fire", 64'(dsp_fire), 64'(efire));
    check("ren_ready", 64'(ren_ready), 64'((n == 0) || efire));
    for (int i = 0; i < 4; i++)
      if (m_v[i])
        check($sformatf("slot%0d", i),
              pack_slot(int'(dsp_op[i*7 +: 7]), int'(dsp_prs1[i*6 +: 6]), dsp_prs1_v[i], dsp_prs1_rdy[i],
                        int'(dsp_prs2[i*6 +: 6]), dsp_prs2_v[i], dsp_prs2_rdy[i],
                        int'(dsp_prd[i*6 +: 6]), dsp_prd_v[i], int'(dsp_age[i*5 +: 5])),
              pack_slot(m_op[i], m_p1[i], m_p1v[i], m_r1[i], m_p2[i], m_p2v[i], m_r2[i],
                        m_pd[i], m_pdv[i], m_age[i]));
    model_step();
  end

  // ---------------- stimulus ----------------
  task automatic clear_in();
    flush = 0; ren_valid = '0; ren_op = '0;
    ren_prs1 = '0; ren_prs2 = '0; ren_prd = '0;
    ren_prs1_v = '0; ren_prs2_v = '0; ren_prd_v = '0;
    wb_valid = '0; wb_prd = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    clear_in();
  endtask

  task automatic set_slot(input int i, input int op, input int p1, input bit p1v,
                          input int p2, input bit p2v, input int pd, input bit pdv);
    ren_op[i*7 +: 7]   = 7'(op);
    ren_prs1[i*6 +: 6] = 6'(p1);
    ren_prs2[i*6 +: 6] = 6'(p2);
    ren_prd[i*6 +: 6]  = 6'(pd);
    ren_prs1_v[i] = p1v;
    ren_prs2_v[i] = p2v;
    ren_prd_v[i]  = pdv;
  endtask

  initial begin
    int pds[4];
    clear_in();
    iq_free_cnt = 5'd16;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("rst_valid", 64'(dsp_valid), 64'd0);
    check("rst_op", 64'(dsp_op), 64'd0);
    check("rst_tags", {16'd0, dsp_prs1, dsp_prs2}, 64'd0);
    check("rst_misc", {24'd0, dsp_age, dsp_prd_v, dsp_prs1_v, dsp_prs2_v, dsp_prs1_rdy, dsp_prs2_rdy}, 64'd0);

    // independent 4-wide group
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_slot(i, i + 1, 0, 1, 1, 1, 5 + i, 1);
    ren_valid = 4'hf;
    #3 check("t1_ready", 64'(ren_ready), 64'd1);

    cyc();
    pds = '{10, 11, 13, 14};
    for (int i = 0; i < 4; i++) set_slot(i, 10 + i, 1, 1, 0, 0, pds[i], 1);
    ren_valid = 4'hf;
    #3;
    check("t1_valid", 64'(dsp_valid), 64'hf);
    check("t1_rdy", 64'({dsp_prs1_rdy, dsp_prs2_rdy}), 64'hff);
    check("t1_age", 64'(dsp_age), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
    check("t1_fire", 64'(dsp_fire), 64'd1);

    // intra-group dependence on p9
    cyc();
    set_slot(0, 20, 1, 1, 0, 0, 9, 1);
    set_slot(1, 21, 1, 1, 0, 0, 15, 1);
    set_slot(2, 22, 9, 1, 1, 1, 16, 1);
    ren_valid = 4'b0111;
    #3 check("t1_age2", 64'(dsp_age), 64'({5'd7, 5'd6, 5'd5, 5'd4}));

    cyc();
    iq_free_cnt = 5'd2;
    set_slot(0, 40, 0, 0, 0, 0, 20, 1);
    ren_valid = 4'b0001;
    wb_valid = 2'b01; wb_prd[5:0] = 6'd9;
    #3;
    check("t2_valid", 64'(dsp_valid), 64'h7);
    check("t2_rdy_dep", 64'(dsp_prs1_rdy[2:0]), 64'b011);
    check("t3_nofire", 64'(dsp_fire), 64'd0);
    check("t3_notready", 64'(ren_ready), 64'd0);

    cyc();
    #3;
    check("t2_wakeup", 64'(dsp_prs1_rdy[2]), 64'd1);
    check("t3_stable", 64'(dsp_prd[17:0]), 64'({6'd16, 6'd15, 6'd9}));

    cyc();
    iq_free_cnt = 5'd3;
    #3;
    check("t3_fire", 64'(dsp_fire), 64'd1);
    check("t3_ready", 64'(ren_ready), 64'd1);

    // busy / bypass interaction on p12
    cyc();
    iq_free_cnt = 5'd16;
    set_slot(0, 30, 1, 1, 0, 0, 12, 1);
    ren_valid = 4'b0001;
    #3 check("t3_drained", 64'(dsp_valid), 64'd0);

    cyc();
    set_slot(0, 31, 12, 1, 0, 1, 17, 1);
    ren_valid = 4'b0001;
    wb_valid = 2'b10; wb_prd[11:6] = 6'd12;

    cyc();
    set_slot(0, 32, 1, 1, 0, 0, 12, 1);
    set_slot(1, 33, 12, 1, 0, 0, 18, 1);
    ren_valid = 4'b0011;
    wb_valid = 2'b01; wb_prd[5:0] = 6'd12;
    #3 check("t4_bypass", 64'(dsp_prs1_rdy[0]), 64'd1);

    cyc();
    set_slot(0, 34, 12, 1, 0, 0, 19, 1);
    ren_valid = 4'b0001;
    #3 check("t4_redef_over_wb", 64'(dsp_prs1_rdy[1]), 64'd0);

    // counter is 16 here; bring it to 30 with 4+4+4+2
    for (int k = 0; k < 4; k++) begin
      cyc();
      for (int i = 0; i < 4; i++) set_slot(i, 50 + i, 0, 0, 0, 0, 0, 0);
      ren_valid = (k < 3) ? 4'hf : 4'h3;
      if (k == 0) #3 check("t4_set_wins", 64'(dsp_prs1_rdy[0]), 64'd0);
    end

    cyc();
    for (int i = 0; i < 4; i++) set_slot(i, 60 + i, 0, 0, 0, 0, 0, 0);
    ren_valid = 4'hf;

    cyc();
    set_slot(0, 64, 0, 0, 0, 0, 0, 0);
    ren_valid = 4'b0001;
    #3 check("t5_wrap", 64'(dsp_age), 64'({5'd1, 5'd0, 5'd31, 5'd30}));

    // flush while holding a group with busy destinations
    cyc();
    set_slot(0, 70, 1, 1, 0, 0, 21, 1);
    set_slot(1, 71, 1, 1, 0, 0, 22, 1);
    ren_valid = 4'b0011;
    #3 check("t5_cnt", 64'(dsp_age[4:0]), 64'd2);

    cyc();
    iq_free_cnt = 5'd0;
    #3 check("t6_held", 64'(dsp_valid), 64'h3);

    cyc();
    iq_free_cnt = 5'd16;
    flush = 1'b1;
    set_slot(0, 72, 0, 0, 0, 0, 23, 1);
    ren_valid = 4'b0001;

    cyc();
    set_slot(0, 73, 21, 1, 22, 1, 24, 1);
    ren_valid = 4'b0001;
    #3 check("t6_flushed", 64'(dsp_valid), 64'd0);

    cyc();
    set_slot(0, 74, 0, 0, 0, 0, 25, 1);
    set_slot(1, 75, 0, 0, 0, 0, 26, 1);
    ren_valid = 4'b0011;
    #3;
    check("t6_rdy", 64'({dsp_prs1_rdy[0], dsp_prs2_rdy[0]}), 64'b11);
    check("t6_age0", 64'(dsp_age[4:0]), 64'd0);

    // asynchronous reset in the middle of a hold
    cyc();
    iq_free_cnt = 5'd0;
    #1 rst_n = 1'b0;
    #2;
    check("t6_async_valid", 64'(dsp_valid), 64'd0);
    check("t6_async_payload", {12'd0, dsp_op[3:0], dsp_prd, dsp_age}, 64'd0);

    cyc();
    rst_n = 1'b1;
    iq_free_cnt = 5'd16;
    cyc();
    cyc();
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
